// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue.
//
// Contents:
//   UART_DATA_W          - byte width handed to the UART
//   DEFAULT_DEPTH        - default FIFO depth (power of two, >= 2)
//   DEFAULT_BUSY_TIMEOUT - default cycles to wait for tx_busy after tx_start
//   tx_q_state_t         - launch FSM states
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } tx_q_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Signal bundle between a byte producer / UART pair and uart_tx_queue.
//
// Signals:
//   in_valid, in_data, in_ready - producer valid/ready byte stream
//   flush                       - drop every queued, not-yet-launched byte
//   tx_start, tx_data, tx_busy  - launch interface toward the UART
//   level, empty                - FIFO occupancy status
//   timeout_err                 - sticky "UART never went busy" flag
//
// Modports:
//   slave  - the queue itself
//   master - the surrounding system (producer, UART, software status)
interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
);

    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_ready;
    logic                     flush;
    logic                     tx_start;
    logic [DATA_W-1:0]        tx_data;
    logic                     tx_busy;
    logic [$clog2(DEPTH):0]   level;
    logic                     empty;
    logic                     timeout_err;

    modport slave (
        input  in_valid, in_data, flush, tx_busy,
        output in_ready, tx_start, tx_data, level, empty, timeout_err
    );

    modport master (
        output in_valid, in_data, flush, tx_busy,
        input  in_ready, tx_start, tx_data, level, empty, timeout_err
    );

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous circular-buffer FIFO without fall-through.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data (ignored when full or flushing)
//   push_data  - byte to store
//   pop        - advance the read pointer (ignored when empty or flushing)
//   pop_data   - current head entry (valid while !empty)
//   flush      - drop every stored entry; wins over push and pop
//   level      - occupancy, 0..DEPTH
//   full       - level == DEPTH
//   empty      - level == 0
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_data,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and level alone define which
    // entries are meaningful, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            // Read pointer catches up with the write pointer: queue empty.
            rd_ptr <= wr_ptr;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit-side byte queue feeding a UART's tx_start/tx_data/tx_busy port.
// Bytes from a valid/ready producer are buffered in a FIFO and launched one
// at a time whenever the UART is idle. If the UART fails to raise tx_busy
// within BUSY_TIMEOUT cycles of a launch, the byte is considered lost and the
// sticky timeout_err flag is raised.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (wins over flush)
//   bus  - uart_tx_queue_if.slave: producer stream, flush, UART launch
//          interface, level/empty status and timeout_err
//
// BUSY_TIMEOUT must be at least 1; DEPTH must be a power of two >= 2.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input logic             clk,
    input logic             rst,
    uart_tx_queue_if.slave  bus
);

    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);

    tx_q_state_t        state;
    tx_q_state_t        state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [DATA_W-1:0]  tx_data_q;
    logic [DATA_W-1:0]  tx_data_nxt;
    logic               tx_start_q;
    logic               tx_start_nxt;
    logic               err_q;
    logic               err_nxt;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;
    logic [LVL_W-1:0]   fifo_level;

    // Readiness depends only on the registered level, never on a same-cycle
    // pop, and is withheld while reset is asserted.
    assign bus.in_ready = !fifo_full && !rst;
    assign fifo_push    = bus.in_valid && bus.in_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .flush     (bus.flush),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_start_q <= tx_start_nxt;
            err_q      <= err_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        tx_data_nxt  = tx_data_q;
        tx_start_nxt = 1'b0;       // launch pulse is exactly one cycle wide
        err_nxt      = err_q;
        fifo_pop     = 1'b0;

        case (state)
            IDLE: begin
                // A flush in the same cycle wins: the head is being discarded.
                if (!fifo_empty && !bus.tx_busy && !bus.flush) begin
                    fifo_pop     = 1'b1;
                    tx_data_nxt  = fifo_head;
                    tx_start_nxt = 1'b1;
                    timer_nxt    = TIMER_W'(BUSY_TIMEOUT);
                    state_nxt    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timer == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.level       = fifo_level;
    assign bus.empty       = fifo_empty;
    assign bus.timeout_err = err_q;

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Transmit-side buffer that sits directly upstream of uart_full_duplex.
- Accepts bytes from a valid/ready producer into a DEPTH-entry FIFO.
- Launches them one at a time into the UART's tx_start/tx_data/tx_busy interface.
- Lets software or a packet engine burst bytes without polling tx_busy per byte.

Parameters:
- DATA_W, 8, byte width passed to the UART.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after a tx_start pulse before treating the byte as lost.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  producer has a byte.
- in_data  in  DATA_W  producer byte.
- in_ready  out  1  FIFO can accept; equals !full.
- flush  in  1  discard all queued, not-yet-launched bytes.
- tx_start  out  1  one-cycle launch pulse to the UART.
- tx_data  out  DATA_W  byte to the UART; held stable from tx_start until the FSM returns to IDLE.
- tx_busy  in  1  UART transmitter busy.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- empty  out  1  level==0.
- timeout_err  out  1  sticky; set when BUSY_TIMEOUT expires; cleared only by rst.

Behaviour:
- All state changes occur on the rising edge of clk.
- rst has priority over everything, including flush. Reset values:
  - FIFO emptied, level=0, empty=1.
  - in_ready=1 in the first cycle after rst deasserts (0 while rst is high).
  - tx_start=0, tx_data=0, timeout_err=0, FSM=IDLE.
- FIFO:
  - Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Push when in_valid && in_ready.
  - Pop only from the FSM launch in IDLE.
  - Push and pop in the same cycle leave level unchanged.
  - in_ready depends only on level, never on the same-cycle pop. A full FIFO refuses pushes even if a pop occurs that cycle.
  - No fall-through: a byte pushed at edge k is first launchable at edge k+1.
- flush:
  - At the edge where flush=1: rd_ptr<=wr_ptr, level<=0.
  - A simultaneous push is discarded.
  - A byte already in tx_data (launched) is not aborted; the FSM continues normally.
- FSM states:
  - IDLE: if !empty && !tx_busy && !flush, pop head into tx_data, tx_start<=1, go to WAIT_BUSY, load timer=BUSY_TIMEOUT. Otherwise stay.
  - WAIT_BUSY:
    - tx_start<=0 on the first cycle in this state (pulse width exactly 1).
    - If tx_busy=1, go to WAIT_DONE.
    - Otherwise decrement timer; at timer==0 set timeout_err, go to IDLE.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency and rate:
  - From idle, with the UART not busy, a push at edge k gives tx_start high in cycle k+1..k+2.
  - At least one IDLE cycle separates consecutive tx_start pulses.
- If tx_busy is already high in IDLE (UART driven elsewhere), no launch occurs until it falls.
- level never exceeds DEPTH and never underflows.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - The FSM enum typedef tx_q_state_t {IDLE, WAIT_BUSY, WAIT_DONE}.
  - Default DEPTH and BUSY_TIMEOUT constants.
- One sub-module, sync_fifo (parameterised DATA_W/DEPTH, push/pop/flush/level/full/empty), instantiated once. The FSM and timeout logic stay in uart_tx_queue.
- Top-level integration wires uart_tx_queue.tx_start/tx_data/tx_busy to uart_full_duplex with rx looped to tx.

Test Plan:
- Single byte: after reset, push 0x5A. Required: tx_start one cycle later, tx_data=0x5A; loopback rx_data=0x5A with rx_data_valid; level returns to 0.
- Burst: push 0x11,0x22,0x33 back-to-back. Required: three tx_start pulses, each only after tx_busy falls; rx sees 0x11,0x22,0x33 in order; tx_data never changes while tx_busy=1.
- Full boundary: with tx_busy forced high, push 17 bytes 0x00..0x10. Required: level=16, in_ready=0 after the 16th; 0x10 is not accepted until the first pop; order is preserved after release.
- Flush mid-frame: queue 0xA1,0xA2,0xA3; assert flush during the 0xA1 transmission. Required: 0xA1 completes; level=0; no further tx_start; empty=1.
- Timeout: hold tx_busy=0 permanently and push 0x7E. Required: tx_start pulse, then timeout_err=1 exactly BUSY_TIMEOUT+1 cycles later; FSM back in IDLE; next byte still launches.
- Reset mid-operation: assert rst while in WAIT_DONE with 5 bytes queued. Required: next cycle level=0, tx_start=0, tx_data=0, timeout_err=0; no further launches.
